// File: rtl/ps2_receiver.sv
// PS/2 keyboard receive front end: synchronises and deglitches kb_clk, then
// deserialises 11-bit frames into scan codes with parity/framing/timeout checks.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] scan_code,
    output logic       valid_code,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic                  clk_s1, clk_s2, data_s1, data_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  clk_filt;
    logic                  fall;
    logic                  strobe;

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [7:0]            sr;
    logic                  par;
    logic [TO_W-1:0]       tcnt;

    // Filtered clock is about to drop: all samples low while the level is still high.
    assign fall = clk_filt && (filt_sr == '0);

    // NOTE: synchronisers and filter reset to the idle-high line level so a
    // reset never fabricates a falling edge on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt_sr  <= '1;
            clk_filt <= 1'b1;
            strobe   <= 1'b0;
        end else begin
            clk_s1   <= kb_clk;
            clk_s2   <= clk_s1;
            data_s1  <= kb_data;
            data_s2  <= data_s1;
            filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr)
                clk_filt <= 1'b1;
            else if (~|filt_sr)
                clk_filt <= 1'b0;
            strobe   <= fall;
        end
    end

    // NOTE: pulse outputs default low every cycle and are set only by the
    // branch that owns them, so they can never overlap or stretch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            scan_code  <= '0;
            valid_code <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid_code <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || strobe)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;

            if (strobe) begin
                unique case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sr      <= {data_s2, sr[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= data_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_s2) begin
                            frame_err <= 1'b1;
                        end else if (^sr ^ par) begin
                            scan_code  <= sr;
                            valid_code <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TO_MAX) begin
                // Keyboard stalled mid-frame: drop the partial byte.
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: drives PS/2 frames and matches every
// output pulse against a queue of expected events.
module tb_ps2_receiver;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF_BIT       = 50;

    typedef enum logic [2:0] {EV_VALID = 3'b100, EV_PERR = 3'b010, EV_FERR = 3'b001} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] scan;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic [7:0] scan_code;
    logic       valid_code, parity_err, frame_err;

    logic       rst_q = 1'b1;
    logic [7:0] prev_scan = 8'h00;
    logic [7:0] model_scan = 8'h00;
    int         cyc = 0;
    int         last_fall = 0;
    int         meas_exp = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
        .scan_code(scan_code), .valid_code(valid_code),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst_q) begin
            if (valid_code || parity_err || frame_err) begin
                check("one_hot", int'(valid_code) + int'(parity_err) + int'(frame_err), 1);
                if (sb.size() == 0) begin
                    check("unexpected_ev", {valid_code, parity_err, frame_err}, 3'b000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ev_kind", {valid_code, parity_err, frame_err}, e.kind);
                    check("scan_code", scan_code, e.scan);
                end
                if (meas_exp != 0) begin
                    check("latency", cyc - last_fall, meas_exp);
                    meas_exp = 0;
                end
            end
            if (scan_code !== prev_scan && !valid_code)
                check("scan_hold", scan_code, prev_scan);
        end
        prev_scan = scan_code;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input ev_t kind, input logic [7:0] code);
        exp_t e;
        if (kind == EV_VALID)
            model_scan = code;
        e.kind = kind;
        e.scan = model_scan;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        kb_data = b;
        wait_cycles(HALF_BIT / 2);
        kb_clk    = 1'b0;
        last_fall = cyc;
        wait_cycles(HALF_BIT);
        kb_clk = 1'b1;
        wait_cycles(HALF_BIT / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stop, input int meas);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
        send_bit(p);
        meas_exp = meas;
        send_bit(stop);
        kb_data = 1'b1;
        wait_cycles(10);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic check_reset_outputs();
        check("rst_scan", scan_code, 8'h00);
        check("rst_valid", valid_code, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
    endtask

    initial begin
        wait_cycles(4);
        check_reset_outputs();
        rst = 1'b0;
        wait_cycles(20);

        // Good frame with pin-to-valid latency measured from the stop edge.
        expect_ev(EV_VALID, 8'h1C);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, FILTER_LEN + 4);

        // Back-to-back frames.
        expect_ev(EV_VALID, 8'hF0);
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 0);
        expect_ev(EV_VALID, 8'h1C);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 0);

        // Parity error, then bad stop bit.
        expect_ev(EV_PERR, 8'h00);
        send_frame(8'h1C, ~odd_par(8'h1C), 1'b1, 0);
        expect_ev(EV_FERR, 8'h00);
        send_frame(8'h1C, odd_par(8'h1C), 1'b0, 0);

        // Short clock glitch with data low must not start a frame.
        kb_data = 1'b0;
        wait_cycles(5);
        kb_clk = 1'b0;
        wait_cycles(3);
        kb_clk = 1'b1;
        wait_cycles(30);
        kb_data = 1'b1;
        wait_cycles(30);
        expect_ev(EV_VALID, 8'h5A);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 0);

        // Timeout after start + 4 data bits.
        expect_ev(EV_FERR, 8'h00);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        meas_exp = FILTER_LEN + 4 + TIMEOUT_CYCLES;
        send_bit(1'b1);
        kb_data = 1'b1;
        wait_cycles(TIMEOUT_CYCLES + 200);
        check("timeout_seen", meas_exp, 0);
        expect_ev(EV_VALID, 8'h29);
        send_frame(8'h29, odd_par(8'h29), 1'b1, 0);

        // Reset mid-frame after the 5th data bit.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++)
            send_bit(i[0]);
        kb_data    = 1'b1;
        rst        = 1'b1;
        model_scan = 8'h00;
        wait_cycles(1);
        check_reset_outputs();
        rst = 1'b0;
        wait_cycles(TIMEOUT_CYCLES + 200);
        expect_ev(EV_VALID, 8'h33);
        send_frame(8'h33, odd_par(8'h33), 1'b1, 0);

        wait_cycles(100);
        check("sb_drain", sb.size(), 0);
        check("final_scan", scan_code, 8'h33);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Serial front end for the keyboard path. It samples the PS/2 `kb_clk`/`kb_data` lines, deglitches the keyboard clock and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good frame is presented as a byte plus a one-cycle `valid_code` strobe to the downstream keyboard controller, which consumes `scan_code`/`valid_code` directly. Break (0xF0) and extended (0xE0) prefixes pass through untouched; interpreting them is the controller's job.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples of synchronised `kb_clk` needed to change the filtered clock level.
- `TIMEOUT_CYCLES`, default 200000: idle cycles inside a frame before the frame is abandoned (2 ms at 100 MHz).
- `clk`  in  1: system clock; the only clock in the block.
- `rst`  in  1: reset. **Synchronous, active-high.**
- `kb_clk`  in  1: PS/2 clock pin, asynchronous to `clk`.
- `kb_data`  in  1: PS/2 data pin, asynchronous to `clk`.
- `scan_code`  out  8: last correctly received byte. Held until the next good frame.
- `valid_code`  out  1: one-cycle pulse when `scan_code` is updated.
- `parity_err`  out  1: one-cycle pulse when a frame fails odd parity.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit or a timeout.

## Operation
- **Synchronisers:** two-flop synchronisers on `kb_clk` and `kb_data`. All logic uses only the synchronised copies.
- **Clock filter:** a `FILTER_LEN`-bit shift register of synchronised `kb_clk`.
  - Filtered clock goes to 1 when all bits are 1, and to 0 when all bits are 0. Otherwise it holds.
  - Filtered clock resets to 1.
- **Falling strobe:** an internal one-cycle pulse when the filtered clock goes 1→0. Synchronised `kb_data` is sampled in the strobe cycle.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - IDLE: strobe with data=0 → DATA, clear `bit_cnt` (3 bits). Strobe with data=1 is a spurious start; stay in IDLE with no output.
  - DATA: on each strobe, shift right with `sr <= {d, sr[7:1]}` and increment `bit_cnt`. The strobe with `bit_cnt`==7 → PARITY.
  - PARITY: strobe captures the parity bit `p` → STOP.
  - STOP, on strobe, always → IDLE, with exactly one of:
    - stop=0: `frame_err` pulse.
    - stop=1 and `^sr ^ p`==0: `parity_err` pulse.
    - stop=1 and `^sr ^ p`==1: `scan_code <= sr` and `valid_code` pulse.
  - Never more than one of the three outputs pulses in the same cycle.
- **Timeout:** a counter of width `$clog2(TIMEOUT_CYCLES)`.
  - Cleared in IDLE and on every strobe; otherwise increments.
  - On reaching `TIMEOUT_CYCLES-1` outside IDLE: → IDLE, `frame_err` pulse, partial data discarded, `scan_code` unchanged.
  - If a strobe occurs in the same cycle the counter reaches `TIMEOUT_CYCLES-1`, the strobe wins and the timeout is ignored.
- **Reset outputs:** `scan_code`=0x00, `valid_code`=0, `parity_err`=0, `frame_err`=0.
- **Reset mid-frame:** discards the partial frame and returns to IDLE. No error pulse.
- **Line level:** the block never drives the PS/2 lines (receive only; no host-to-device).

## Timing
- `valid_code`/error pulses are registered and one `clk` cycle wide.
- They assert in the cycle after the stop-bit strobe.
- Pin-to-strobe latency is fixed at 2 (sync) + `FILTER_LEN` + 1 cycles after `kb_clk` falls and stays low. Pin-to-`valid_code` is therefore `FILTER_LEN`+4 cycles.
- Data sampling point: synchronised `kb_data` in the strobe cycle, i.e. `FILTER_LEN`+1 cycles after the clock edge. This is well inside the ≥5 µs PS/2 data-valid window at 100 MHz.
- `kb_clk` pulses shorter than `FILTER_LEN` cycles (high or low) are invisible.
- Back-to-back frames need no gap beyond the PS/2 stop bit. The FSM is in IDLE on the cycle after the STOP strobe.
- `scan_code` changes only in the same cycle that `valid_code` is high.

## Test plan
- Good frame: byte 0x1C, p=0, stop=1 at 12.5 kHz → `scan_code`=0x1C and a single `valid_code` pulse `FILTER_LEN`+4 cycles after the stop falling edge; no error pulses.
- Back-to-back frames 0xF0 then 0x1C → two `valid_code` pulses; `scan_code` reads 0xF0 then 0x1C.
- Parity and frame errors:
  - 0x1C with p=1 → one `parity_err` pulse; `scan_code` keeps its previous value; no `valid_code`.
  - Stop=0 → one `frame_err` pulse.
- Glitch: 3-cycle low pulse on `kb_clk` in IDLE with `kb_data`=0 (`FILTER_LEN`=8) → FSM stays IDLE. A following good 0x5A frame yields `scan_code`=0x5A.
- Timeout (bench overrides `TIMEOUT_CYCLES`=1000): start + 4 data bits, then lines idle high → `frame_err` exactly once after 1000 cycles; next frame 0x29 is received correctly.
- Reset: assert `rst` for 1 cycle after the 5th data bit → all outputs 0 next cycle, no error pulse; next frame 0x33 → `scan_code`=0x33.
